pc_sequencer: RTL
=================

# pc_sequencer

Fetch/sequence controller for the 8-bit single-cycle processor. Owns the program counter driving the instruction memory address, decodes the control-flow opcodes (jump, BEQ, halt), and gates datapath commits with a one-cycle execute enable. Supports free-run and single-step modes. Arbitrates the instruction-memory write port for a program loader while the core is idle or halted.

## Interface
- PC_W, 8, program counter / instruction address width
- CNT_W, 16, retired-instruction counter width
- START_ADDR, 0, PC value loaded on reset and on every start

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; begin execution from START_ADDR (IDLE/HALT only)
- step_mode  in  1  1 = advance only on step_req; 0 = free-run
- step_req  in  1  request one instruction in step mode
- step_ack  out  1  one-cycle pulse when a stepped instruction commits
- OPcode  in  4  opcode of instruction at endereco (combinational from memory)
- label  in  6  label field of same instruction
- igual  in  1  datapath comparison result for BEQ (1 = taken)
- endereco  out  PC_W  instruction address (registered PC)
- exec_en  out  1  datapath commit enable for instruction at endereco
- running  out  1  state == RUN
- halted  out  1  state == HALT
- retired  out  CNT_W  committed-instruction count, saturating
- load_req  in  1  loader requests a memory write this cycle
- load_addr  in  6  loader write address
- load_data  in  8  loader write data
- load_grant  out  1  combinational: load_req accepted this cycle
- mem_we  out  1  instruction-memory write enable (= load_grant)
- mem_waddr  out  6  = load_addr
- mem_wdata  out  8  = load_data

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE, endereco=START_ADDR, retired=0, all pulses 0.
- Decode of OPcode at endereco: [3:2]==00 jump; [3:2]==01 BEQ; 4'b1100 halt; else sequential.
- Commit (exec_en=1) happens in RUN when step_mode=0, or step_mode=1 and step_req=1. On commit:
  - jump: PC <= {0, label}; BEQ: PC <= igual ? {0, label} : PC+1; other: PC <= PC+1 (mod 2^PC_W, 255 -> 0).
  - retired <= retired+1, saturates at all-ones.
  - step_mode=1: step_ack=1 in the cycle following the commit.
- Halt opcode in RUN: exec_en=0, PC holds, -> HALT next cycle; halt is not counted in retired.
- No commit (step_mode=1, step_req=0): PC, retired unchanged, exec_en=0.
- IDLE/HALT: exec_en=0. start=1 and load_req=0 -> RUN, PC <= START_ADDR, retired <= 0.
- Loader: load_grant = load_req & (state != RUN). In RUN, load_req ignored, no write.
- Simultaneous start and load_req in IDLE/HALT: write granted, start ignored that cycle.
- step_mode may change at any time; takes effect on the next cycle's commit decision.
- reset mid-RUN: aborts, next cycle IDLE, PC=START_ADDR, retired=0; no commit in the reset cycle.

## Timing
- endereco registered; OPcode/label/igual valid combinationally within the same cycle.
- exec_en combinational from state, step_mode, step_req, OPcode; valid same cycle as the instruction.
- Free-run: one instruction per cycle; PC update visible the cycle after commit.
- start -> running=1 next cycle; first commit in that cycle.
- Halt fetched in cycle N -> halted=1 in N+1.
- step_req held high in step mode behaves as free-run; step_ack is high every cycle after each commit.
- load_grant/mem_we zero-latency; memory write completes at the rising edge.

## Test plan
- Reset, start=1 one cycle, sequential ops at 0..3 -> endereco 0,1,2,3 on consecutive cycles, exec_en=1 each, retired=4 after 4 commits.
- Jump at address 39 with label 10 -> endereco=10 next cycle; BEQ label 40 with igual=0 -> PC+1, igual=1 -> endereco=40.
- 4'b1100 at address 40 -> exec_en=0, halted=1 next cycle, endereco stays 40, retired unchanged; start -> endereco=0, retired=0.
- step_mode=1, step_req pulsed at cycles 5 and 9 -> exactly two commits, step_ack high at cycles 6 and 10, PC static otherwise.
- load_req in RUN -> load_grant=0, mem_we=0; load_req with start in HALT -> mem_we=1, addr/data forwarded, state stays HALT.
- reset asserted mid-RUN at PC=17 -> next cycle IDLE, endereco=0, retired=0, exec_en=0; PC 255 sequential commit wraps to 0 (PC_W=8).

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - program loader request and instruction-memory write port bundle
interface pc_sequencer_if;
    logic       load_req;
    logic [5:0] load_addr;
    logic [7:0] load_data;
    logic       load_grant;
    logic       mem_we;
    logic [5:0] mem_waddr;
    logic [7:0] mem_wdata;

    modport master (
        output load_req, load_addr, load_data,
        input  load_grant, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  load_req, load_addr, load_data,
        output load_grant, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/sequence controller: PC, control-flow decode, commit gating, loader arbitration
module pc_sequencer #(
    parameter int PC_W       = 8,
    parameter int CNT_W      = 16,
    parameter int START_ADDR = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             step_ack,
    input  logic [3:0]       OPcode,
    input  logic [5:0]       label,
    input  logic             igual,
    output logic [PC_W-1:0]  endereco,
    output logic             exec_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    pc_sequencer_if.slave    lb
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] retired_nxt;
    logic             step_ack_nxt;
    logic             is_jump, is_beq, is_halt, advance;

    always_comb begin
        is_jump = (OPcode[3:2] == 2'b00);
        is_beq  = (OPcode[3:2] == 2'b01);
        is_halt = (OPcode == 4'b1100);
    end

    // Loader owns the write port whenever the core is not executing
    always_comb begin
        lb.load_grant = lb.load_req && (state != S_RUN);
        lb.mem_we     = lb.load_grant;
        lb.mem_waddr  = lb.load_addr;
        lb.mem_wdata  = lb.load_data;
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = endereco;
        retired_nxt  = retired;
        step_ack_nxt = 1'b0;
        exec_en      = 1'b0;
        advance      = (state == S_RUN) && (!step_mode || step_req);

        case (state)
            S_RUN: begin
                if (advance) begin
                    if (is_halt) begin
                        state_nxt = S_HALT;
                    end else begin
                        exec_en      = !reset;
                        step_ack_nxt = step_mode;
                        if (is_jump || (is_beq && igual)) begin
                            pc_nxt = PC_W'(label);
                        end else begin
                            pc_nxt = endereco + 1'b1;
                        end
                        if (retired != {CNT_W{1'b1}}) begin
                            retired_nxt = retired + 1'b1;
                        end
                    end
                end
            end
            default: begin
                // A simultaneous load request wins; start is retried next cycle
                if (start && !lb.load_req) begin
                    state_nxt   = S_RUN;
                    pc_nxt      = START_PC;
                    retired_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            endereco <= START_PC;
            retired  <= '0;
            step_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            endereco <= pc_nxt;
            retired  <= retired_nxt;
            step_ack <= step_ack_nxt;
        end
    end

    assign running = (state == S_RUN);
    assign halted  = (state == S_HALT);
endmodule
